// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock: controller state encoding and keycodes.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_CHECK   = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_SET     = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    localparam logic [7:0] KEY_ENTER = 8'd10;
    localparam logic [7:0] KEY_CLEAR = 8'd11;
    localparam logic [7:0] KEY_SET   = 8'd12;

endpackage

// File: rtl/lock_timer.sv
// 32-bit loadable down-counter; holds at zero and flags terminal count.
module lock_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        dec_i,
    output logic        zero_o
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 32'd0)) begin
            count_d = count_q - 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 32'd0);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: code check, timed unlock, retry lockout and code change.
//
// state   | meaning
// LOCKED  | idle, accumulating digits
// CHECK   | one-cycle compare of typed against stored code
// CLEAR   | one-cycle accumulator flush
// OPEN    | actuator open until timer expires or ENTER
// SET     | accumulating a new code
// LOCKOUT | all presses ignored until timer expires
module lock_controller
    import lock_pkg::*;
#(
    parameter logic [31:0] DEFAULT_CODE   = 32'd1234,
    parameter int          MAX_TRIES      = 3,
    parameter int          UNLOCK_CYCLES  = 60_000_000,
    parameter int          LOCKOUT_CYCLES = 120_000_000
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic        button_pressed,
    input  logic [7:0]  key,
    input  logic [31:0] typed,
    output logic        entry_enable,
    output logic        unlocked,
    output logic        lockout,
    output logic        set_mode,
    output logic [1:0]  fail_count
);

    localparam logic [2:0]  MAX_T        = 3'(MAX_TRIES);
    localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
    localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [1:0]  fail_q, fail_d;
    logic        btn_q;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic [31:0] tmr_val;
    logic [2:0]  tries_next;

    logic press_evt, enter_evt, clear_evt, set_evt;

    assign press_evt  = button_pressed & ~btn_q;
    assign enter_evt  = press_evt && (key == KEY_ENTER);
    assign clear_evt  = press_evt && (key == KEY_CLEAR);
    assign set_evt    = press_evt && (key == KEY_SET);
    assign tries_next = {1'b0, fail_q} + 3'd1;

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_val  = 32'd0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                if (enter_evt) begin
                    state_d = ST_CHECK;
                end else if (clear_evt) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CHECK: begin
                if (typed == code_q) begin
                    state_d  = ST_OPEN;
                    fail_d   = 2'd0;
                    tmr_load = 1'b1;
                    tmr_val  = UNLOCK_LOAD;
                end else if (tries_next >= MAX_T) begin
                    state_d  = ST_LOCKOUT;
                    fail_d   = 2'd0;
                    tmr_load = 1'b1;
                    tmr_val  = LOCKOUT_LOAD;
                end else begin
                    state_d = ST_CLEAR;
                    fail_d  = tries_next[1:0];
                end
            end
            ST_CLEAR: state_d = ST_LOCKED;
            ST_OPEN: begin
                tmr_dec = 1'b1;
                // Expiry takes priority over a coincident SET press.
                if (tmr_zero || enter_evt) begin
                    state_d = ST_CLEAR;
                end else if (set_evt) begin
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                if (enter_evt) begin
                    if (typed != 32'd0) begin
                        code_d = typed;
                    end
                    state_d = ST_CLEAR;
                end else if (clear_evt) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_LOCKOUT: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_LOCKED;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOCKED;
            code_q  <= DEFAULT_CODE;
            fail_q  <= 2'd0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fail_q  <= fail_d;
            btn_q   <= button_pressed;
        end
    end

    lock_timer u_timer (
        .clk_i      (hwclk),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign entry_enable = (state_q == ST_LOCKED) || (state_q == ST_SET);
    assign unlocked     = (state_q == ST_OPEN);
    assign lockout      = (state_q == ST_LOCKOUT);
    assign set_mode     = (state_q == ST_SET);
    assign fail_count   = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: directed scenarios plus random keypad traffic.
module tb_lock_controller;

    localparam int U   = 10;
    localparam int L   = 20;
    localparam int MAX = 3;

    localparam int M_LOCKED  = 0;
    localparam int M_CHECK   = 1;
    localparam int M_CLEAR   = 2;
    localparam int M_OPEN    = 3;
    localparam int M_SET     = 4;
    localparam int M_LOCKOUT = 5;

    logic        hwclk = 1'b0;
    logic        reset = 1'b1;
    logic        button_pressed = 1'b0;
    logic [7:0]  key = 8'd0;
    logic [31:0] typed = 32'd0;
    logic        entry_enable, unlocked, lockout, set_mode;
    logic [1:0]  fail_count;
    logic [5:0]  outs;

    int vectors = 0;
    int miscompares = 0;

    int          m_mode;
    int          m_remain;
    int          m_fails;
    logic [31:0] m_code;
    logic        m_prev_bp;

    logic [5:0] exp_q[$];

    lock_controller #(
        .DEFAULT_CODE   (32'd1234),
        .MAX_TRIES      (MAX),
        .UNLOCK_CYCLES  (U),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .hwclk          (hwclk),
        .reset          (reset),
        .button_pressed (button_pressed),
        .key            (key),
        .typed          (typed),
        .entry_enable   (entry_enable),
        .unlocked       (unlocked),
        .lockout        (lockout),
        .set_mode       (set_mode),
        .fail_count     (fail_count)
    );

    assign outs = {entry_enable, unlocked, lockout, set_mode, fail_count};

    always #5 hwclk = ~hwclk;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: ee/ul/lo/sm/fc got %b expected %b", name, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode    = M_LOCKED;
        m_remain  = 0;
        m_fails   = 0;
        m_code    = 32'd1234;
        m_prev_bp = 1'b0;
    endfunction

    // Advance the reference by one clock using the inputs the DUT just sampled.
    function automatic void model_advance();
        logic evt;
        evt = button_pressed && !m_prev_bp;
        m_prev_bp = button_pressed;
        case (m_mode)
            M_LOCKED: begin
                if (evt && key == 8'd10) m_mode = M_CHECK;
                else if (evt && key == 8'd11) m_mode = M_CLEAR;
            end
            M_CHECK: begin
                if (typed == m_code) begin
                    m_mode = M_OPEN; m_fails = 0; m_remain = U;
                end else if (m_fails + 1 == MAX) begin
                    m_mode = M_LOCKOUT; m_fails = 0; m_remain = L;
                end else begin
                    m_fails = m_fails + 1; m_mode = M_CLEAR;
                end
            end
            M_CLEAR: m_mode = M_LOCKED;
            M_OPEN: begin
                m_remain = m_remain - 1;
                if (m_remain == 0 || (evt && key == 8'd10)) m_mode = M_CLEAR;
                else if (evt && key == 8'd12) m_mode = M_SET;
            end
            M_SET: begin
                if (evt && key == 8'd10) begin
                    if (typed != 32'd0) m_code = typed;
                    m_mode = M_CLEAR;
                end else if (evt && key == 8'd11) begin
                    m_mode = M_CLEAR;
                end
            end
            default: begin
                m_remain = m_remain - 1;
                if (m_remain == 0) m_mode = M_LOCKED;
            end
        endcase
    endfunction

    function automatic logic [5:0] model_outs();
        logic ee;
        ee = (m_mode == M_LOCKED) || (m_mode == M_SET);
        return {ee, m_mode == M_OPEN, m_mode == M_LOCKOUT, m_mode == M_SET, 2'(m_fails)};
    endfunction

    task automatic step(input logic bp, input logic [7:0] k, input logic [31:0] t);
        @(posedge hwclk);
        #1;
        model_advance();
        exp_q.push_back(model_outs());
        button_pressed = bp;
        key = k;
        typed = t;
    endtask

    task automatic press(input logic [7:0] k, input logic [31:0] t, input int hold, input int gap);
        for (int i = 0; i < hold; i++) step(1'b1, k, t);
        for (int i = 0; i < gap; i++) step(1'b0, k, t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, key, typed);
    endtask

    // Reset is asserted between clock edges and checked before any edge arrives.
    task automatic do_reset(input string name);
        @(negedge hwclk);
        #1;
        reset = 1'b1;
        button_pressed = 1'b0;
        #1;
        check(name, outs, 6'b100000);
        model_reset();
        @(posedge hwclk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] e;
        forever begin
            @(negedge hwclk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("outs", outs, e);
            end
        end
    end

    initial begin
        logic [7:0]  k;
        logic [31:0] t;
        int          sel;
        model_reset();
        do_reset("reset_initial");

        // correct code opens for U cycles, then CLEAR, then LOCKED
        press(8'd10, 32'd1234, 1, 2);
        idle(U + 3);

        // three wrong codes into lockout; presses during lockout ignored
        press(8'd10, 32'd999, 1, 3);
        press(8'd10, 32'd999, 1, 3);
        press(8'd10, 32'd999, 1, 3);
        press(8'd10, 32'd1234, 1, 2);
        press(8'd11, 32'd1234, 1, 2);
        idle(L);

        // SET with typed=0 and SET then CLEAR keep the code
        press(8'd10, 32'd1234, 1, 2);
        press(8'd12, 32'd1234, 1, 2);
        press(8'd10, 32'd0, 1, 3);
        press(8'd10, 32'd1234, 1, 2);
        press(8'd12, 32'd1234, 1, 2);
        press(8'd11, 32'd7777, 1, 3);
        press(8'd10, 32'd1234, 1, 2);
        idle(U + 3);

        // change code to 5555
        press(8'd10, 32'd1234, 1, 2);
        press(8'd12, 32'd1234, 1, 2);
        press(8'd10, 32'd5555, 1, 3);
        press(8'd10, 32'd1234, 1, 3);
        press(8'd10, 32'd5555, 1, 2);
        idle(U + 3);

        // held ENTER gives exactly one check
        press(8'd10, 32'd1, 50, 3);

        // reset mid-SET restores default code
        press(8'd10, 32'd5555, 1, 2);
        press(8'd12, 32'd5555, 1, 2);
        press(8'd3, 32'd42, 1, 1);
        do_reset("reset_mid_set");
        press(8'd10, 32'd1234, 1, 2);
        idle(U + 3);

        // reset mid-LOCKOUT
        press(8'd10, 32'd8, 1, 3);
        press(8'd10, 32'd8, 1, 3);
        press(8'd10, 32'd8, 1, 5);
        do_reset("reset_mid_lockout");
        press(8'd10, 32'd1234, 1, 3);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 9));
            if (m_mode == M_OPEN && sel < 4) k = 8'd12;
            else if (sel < 4) k = 8'd10;
            else if (sel == 4) k = 8'd11;
            else if (sel == 5) k = 8'd12;
            else if (sel < 9) k = 8'($urandom_range(0, 6));
            else k = 8'($urandom_range(13, 255));
            sel = int'($urandom_range(0, 9));
            if (sel < 5) t = m_code;
            else if (sel == 5) t = 32'd0;
            else if (sel == 6) t = 32'd1234;
            else t = $urandom;
            press(k, t, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        end

        idle(3);
        @(negedge hwclk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 Parameter DEFAULT_CODE, 32'd1234, code loaded into code register at reset.
REQ-002 Parameter MAX_TRIES, 3, consecutive wrong codes that trigger lockout (range 1..3).
REQ-003 Parameter UNLOCK_CYCLES, 60_000_000, cycles the lock stays open (5 s at 12 MHz).
REQ-004 Parameter LOCKOUT_CYCLES, 120_000_000, cycles of lockout (10 s at 12 MHz).
REQ-005 hwclk  in  1  system clock, 12 MHz, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; forces the reset state of REQ-030 immediately.
REQ-007 button_pressed  in  1  keypad level, high while any key is held.
REQ-008 key  in  8  keycode: 0-6 digits, 10 ENTER, 11 CLEAR, 12 SET, others ignored.
REQ-009 typed  in  32  decimal value from the digit accumulator.
REQ-010 entry_enable  out  1  accumulator enable; low clears the accumulator.
REQ-011 unlocked  out  1  lock actuator, high = open.
REQ-012 lockout  out  1  high during lockout.
REQ-013 set_mode  out  1  high while a new code is being entered.
REQ-014 fail_count  out  2  consecutive wrong attempts.

Function
REQ-015 Press event SHALL be the rising edge of button_pressed, from a registered copy; one event per press; held keys give no repeats.
REQ-016 States SHALL be LOCKED, CHECK, CLEAR, OPEN, SET, LOCKOUT; outputs SHALL be Moore decodes of state.
REQ-017 entry_enable SHALL be 1 in LOCKED and SET, 0 elsewhere.
REQ-018 unlocked SHALL be 1 only in OPEN; lockout only in LOCKOUT; set_mode only in SET.
REQ-019 LOCKED: ENTER -> CHECK; CLEAR -> CLEAR; all other events leave state unchanged.
REQ-020 CHECK (one cycle) SHALL compare all 32 bits of typed with code_reg, both unsigned.
REQ-021 Match SHALL go to OPEN, zero fail_count and load the timer with UNLOCK_CYCLES-1.
REQ-022 Mismatch with fail_count+1 < MAX_TRIES SHALL increment fail_count and go to CLEAR.
REQ-023 Mismatch with fail_count+1 == MAX_TRIES SHALL go to LOCKOUT, zero fail_count and load LOCKOUT_CYCLES-1.
REQ-024 CLEAR SHALL last one cycle, then go to LOCKED.
REQ-025 OPEN: timer decrements each cycle; timer==0 or ENTER -> CLEAR; SET -> SET; ENTER and expiry together -> CLEAR.
REQ-026 SET: ENTER with typed != 0 -> code_reg <= typed, then CLEAR; ENTER with typed == 0 -> CLEAR, code unchanged; CLEAR -> CLEAR, code unchanged.
REQ-027 LOCKOUT SHALL ignore all press events; timer==0 -> LOCKED.
REQ-028 Press events in CHECK or CLEAR SHALL be dropped, not queued.
REQ-029 OPEN -> LOCKED latency SHALL be exactly UNLOCK_CYCLES+1 cycles, the +1 being CLEAR.

Reset
REQ-030 On reset: state LOCKED, code_reg=DEFAULT_CODE, fail_count=0, timer=0, unlocked=0, lockout=0, set_mode=0, entry_enable=1, press register=0.
REQ-031 Reset in any state, including mid-SET, SHALL discard pending entries and restore DEFAULT_CODE.

Structure
REQ-032 A shared package lock_pkg SHALL hold the state encoding and key codes KEY_ENTER=10, KEY_CLEAR=11, KEY_SET=12.
REQ-033 Down-counter SHALL be sub-module lock_timer (32-bit, load/decrement/zero flag).
REQ-034 Controller SHALL instantiate no accumulator; it drives one through entry_enable.

Verification (UNLOCK_CYCLES=10, LOCKOUT_CYCLES=20, MAX_TRIES=3)
REQ-035 Bench: typed=1234, ENTER -> unlocked=1 for 10 cycles, then one CLEAR cycle, then LOCKED; fail_count=0.
REQ-036 Bench: three ENTERs with typed=999 -> fail_count 1, 2; third -> lockout=1 for 20 cycles; presses ignored; then LOCKED, fail_count=0.
REQ-037 Bench: open, SET, typed=5555, ENTER -> LOCKED; typed=1234 fails; typed=5555 opens.
REQ-038 Bench: SET then ENTER with typed=0 -> code stays 1234; SET then CLEAR -> code unchanged.
REQ-039 Bench: button_pressed held 50 cycles with ENTER -> exactly one CHECK.
REQ-040 Bench: reset asserted mid-SET and mid-LOCKOUT -> all outputs at REQ-030 values with no clock edge; code 1234.
